adjust_mode_ctrl: RTL and testbench
===================================

ADJUST_MODE_CTRL -- requirements
Module: adjust_mode_ctrl

Interface
REQ-001 Parameter HOLD_CYC, default 25000000, clk cycles from the first step pulse to the first auto-repeat pulse.
REQ-002 Parameter RPT_CYC, default 5000000, clk cycles between auto-repeat pulses.
REQ-003 Parameter TIMEOUT_S, default 30, t_1s ticks without key activity before adjust mode is abandoned.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 t_1s  input  1  one-cycle 1 Hz tick, the same tick that drives the time counters.
REQ-007 btn_mode  input  1  one-cycle pulse, debounced mode key.
REQ-008 btn_up  input  1  debounced level, up key held.
REQ-009 btn_down  input  1  debounced level, down key held.
REQ-010 adj_en  output  6  one-hot field select {year,month,day,hour,min,sec} = bits [5:0]; 0 in run mode.
REQ-011 adj_up  output  1  one-cycle increment step to the selected field counter.
REQ-012 adj_down  output  1  one-cycle decrement step to the selected field counter.
REQ-013 blink  output  1  display blank toggle for the selected field.
REQ-014 adj_active  output  1  high in any adjust state.

Function
REQ-015 FSM states: RUN, A_SEC, A_MIN, A_HOUR, A_DAY, A_MON, A_YEAR; adj_en is the registered one-hot decode (RUN=0, A_SEC=bit0 ... A_YEAR=bit5).
REQ-016 btn_mode pulse advances RUN->A_SEC->A_MIN->A_HOUR->A_DAY->A_MON->A_YEAR->RUN; adj_en changes in the cycle after the pulse.
REQ-017 In RUN, btn_up/btn_down produce no pulses and the repeat and timeout counters are held at 0.
REQ-018 Edge detection: a key is "pressed" when sampled 1 with its previous sample 0; adj_up (or adj_down) is high for exactly the one cycle following that clock edge.
REQ-019 While exactly one key stays held, the first repeat pulse occurs HOLD_CYC cycles after the press pulse and subsequent pulses every RPT_CYC cycles; release clears the repeat counter.
REQ-020 Both keys high: no pulses, repeat counter cleared; pressing the second key while the first is held cancels repeat until both are released and one is pressed again.
REQ-021 adj_up and adj_down are never high together, never high while adj_en is 0, and are always coincident with a one-hot adj_en.
REQ-022 btn_mode in the same cycle as a press edge: the state advances and the step pulse is suppressed; repeat counter cleared.
REQ-023 Timeout counter counts t_1s ticks in adjust states; it is cleared by btn_mode, every adj_up/adj_down pulse, and by either key being held; on reaching TIMEOUT_S the FSM returns to RUN in the next cycle.
REQ-024 blink toggles on each t_1s in adjust states, forced 0 in RUN and on each state change.
REQ-025 adj_active = (state != RUN), registered with adj_en.
REQ-026 Repeat counter width = ceiling(log2(max(HOLD_CYC, RPT_CYC)+1)); timeout counter width = ceiling(log2(TIMEOUT_S+1)); no wrap beyond the terminal count.

Reset
REQ-027 On rst: state RUN, adj_en=0, adj_up=0, adj_down=0, blink=0, adj_active=0, all counters 0.
REQ-028 On rst, previous-sample registers of btn_up/btn_down load 1, so a key held through reset produces no pulse until released and re-pressed.
REQ-029 rst asserted mid-adjust or mid-repeat takes effect at the next edge regardless of other inputs; rst has priority over all events.

Verification
REQ-030 Reset, then 7 btn_mode pulses -> adj_en 000001,000010,000100,001000,010000,100000,000000; adj_active falls with the last.
REQ-031 HOLD_CYC=10, RPT_CYC=4, A_MIN, btn_up held 30 cycles -> adj_up pulses at cycles 1, 11, 15, 19, 23, 27 after press; adj_en=000010 throughout.
REQ-032 A_HOUR, btn_up then btn_down held together -> single adj_up, no further pulses; release both, press btn_down -> one adj_down.
REQ-033 TIMEOUT_S=3, A_DAY, no keys, 3 t_1s ticks -> RUN next cycle, adj_en=0, blink=0; a key press at tick 2 restarts the count.
REQ-034 btn_mode and btn_up rising in the same cycle in A_SEC -> adj_en=000010, no adj_up pulse.
REQ-035 btn_up held across rst in A_YEAR -> after reset RUN, no pulse; RUN with btn_up toggled -> no adj_up.

Source files
------------

// File: rtl/adjust_mode_if.sv
// Key/tick inputs and field-adjust outputs of the time-setting controller.
// master drives the keys and tick, slave is the controller.
interface adjust_mode_if;
  logic       t_1s;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic [5:0] adj_en;
  logic       adj_up;
  logic       adj_down;
  logic       blink;
  logic       adj_active;

  modport master (
    output t_1s, btn_mode, btn_up, btn_down,
    input  adj_en, adj_up, adj_down, blink, adj_active
  );

  modport slave (
    input  t_1s, btn_mode, btn_up, btn_down,
    output adj_en, adj_up, adj_down, blink, adj_active
  );
endinterface

// File: rtl/adjust_mode_ctrl.sv
// Clock/calendar adjust controller: mode key walks the fields, up/down keys
// issue single steps with hold-to-repeat, and inactivity drops back to RUN.
module adjust_mode_ctrl #(
  parameter int HOLD_CYC  = 25000000,
  parameter int RPT_CYC   = 5000000,
  parameter int TIMEOUT_S = 30
) (
  input  logic        clk,
  input  logic        rst,
  adjust_mode_if.slave bus
);

  localparam int RPT_MAX = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
  localparam int RW_RAW  = $clog2(RPT_MAX + 1);
  localparam int TW_RAW  = $clog2(TIMEOUT_S + 1);
  localparam int RW      = (RW_RAW < 1) ? 1 : RW_RAW;
  localparam int TW      = (TW_RAW < 1) ? 1 : TW_RAW;
  localparam logic [RW-1:0] HOLD_T = RW'(HOLD_CYC);
  localparam logic [RW-1:0] RPT_T  = RW'(RPT_CYC);
  localparam logic [TW-1:0] TO_T   = TW'(TIMEOUT_S);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    A_SEC  = 3'd1,
    A_MIN  = 3'd2,
    A_HOUR = 3'd3,
    A_DAY  = 3'd4,
    A_MON  = 3'd5,
    A_YEAR = 3'd6
  } state_t;

  state_t        state_reg, state_next;
  logic [RW-1:0] rpt_cnt_reg, rpt_cnt_next;
  logic [TW-1:0] to_cnt_reg, to_cnt_next;
  logic          first_done_reg, first_done_next;
  logic          arm_reg, arm_next;
  logic          up_prev_reg, down_prev_reg;
  logic          adj_up_reg, adj_up_next;
  logic          adj_down_reg, adj_down_next;
  logic          blink_reg, blink_next;
  logic [5:0]    adj_en_reg, en_dec;
  logic          adj_active_reg;

  logic in_adj, one_held, press_up, press_down;

  assign in_adj     = (state_reg != RUN);
  assign one_held   = bus.btn_up ^ bus.btn_down;
  // A press only counts when the other key is up; a press onto a held key is a both-keys case.
  assign press_up   = bus.btn_up & ~up_prev_reg & ~bus.btn_down;
  assign press_down = bus.btn_down & ~down_prev_reg & ~bus.btn_up;

  always_comb begin
    state_next = state_reg;
    if (bus.btn_mode) begin
      case (state_reg)
        RUN:     state_next = A_SEC;
        A_SEC:   state_next = A_MIN;
        A_MIN:   state_next = A_HOUR;
        A_HOUR:  state_next = A_DAY;
        A_DAY:   state_next = A_MON;
        A_MON:   state_next = A_YEAR;
        default: state_next = RUN;
      endcase
    end else if (in_adj && to_cnt_reg == TO_T) begin
      state_next = RUN;
    end
  end

  for (genvar gi = 0; gi < 6; gi++) begin : g_dec
    assign en_dec[gi] = (state_next == state_t'(3'(gi + 1)));
  end

  always_comb begin
    rpt_cnt_next    = rpt_cnt_reg;
    first_done_next = first_done_reg;
    arm_next        = arm_reg;
    adj_up_next     = 1'b0;
    adj_down_next   = 1'b0;
    if (!in_adj || bus.btn_mode || !one_held || state_next == RUN) begin
      rpt_cnt_next    = '0;
      first_done_next = 1'b0;
      arm_next        = 1'b0;
    end else if (press_up || press_down) begin
      adj_up_next     = bus.btn_up;
      adj_down_next   = bus.btn_down;
      rpt_cnt_next    = RW'(1);
      first_done_next = 1'b0;
      arm_next        = 1'b1;
    end else if (arm_reg) begin
      // Counter holds cycles since the last step; the terminal count shortens after the first repeat.
      if (rpt_cnt_reg == (first_done_reg ? RPT_T : HOLD_T)) begin
        adj_up_next     = bus.btn_up;
        adj_down_next   = bus.btn_down;
        rpt_cnt_next    = RW'(1);
        first_done_next = 1'b1;
      end else begin
        rpt_cnt_next = rpt_cnt_reg + RW'(1);
      end
    end
  end

  always_comb begin
    to_cnt_next = to_cnt_reg;
    if (!in_adj || bus.btn_mode || state_next == RUN) begin
      to_cnt_next = '0;
    end else if (bus.btn_up || bus.btn_down || adj_up_next || adj_down_next) begin
      to_cnt_next = '0;
    end else if (bus.t_1s && to_cnt_reg != TO_T) begin
      to_cnt_next = to_cnt_reg + TW'(1);
    end

    blink_next = blink_reg;
    if (state_next == RUN || state_next != state_reg) begin
      blink_next = 1'b0;
    end else if (bus.t_1s) begin
      blink_next = ~blink_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= RUN;
      rpt_cnt_reg    <= '0;
      to_cnt_reg     <= '0;
      first_done_reg <= 1'b0;
      arm_reg        <= 1'b0;
      up_prev_reg    <= 1'b1;
      down_prev_reg  <= 1'b1;
      adj_up_reg     <= 1'b0;
      adj_down_reg   <= 1'b0;
      blink_reg      <= 1'b0;
      adj_en_reg     <= '0;
      adj_active_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rpt_cnt_reg    <= rpt_cnt_next;
      to_cnt_reg     <= to_cnt_next;
      first_done_reg <= first_done_next;
      arm_reg        <= arm_next;
      up_prev_reg    <= bus.btn_up;
      down_prev_reg  <= bus.btn_down;
      adj_up_reg     <= adj_up_next;
      adj_down_reg   <= adj_down_next;
      blink_reg      <= blink_next;
      adj_en_reg     <= en_dec;
      adj_active_reg <= (state_next != RUN);
    end
  end

  assign bus.adj_en     = adj_en_reg;
  assign bus.adj_up     = adj_up_reg;
  assign bus.adj_down   = adj_down_reg;
  assign bus.blink      = blink_reg;
  assign bus.adj_active = adj_active_reg;

endmodule

// File: tb/tb_adjust_mode_ctrl.sv
// Directed checks of adjust_mode_ctrl with short repeat/timeout parameters.
module tb_adjust_mode_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  adjust_mode_if bus ();

  adjust_mode_ctrl #(.HOLD_CYC(10), .RPT_CYC(4), .TIMEOUT_S(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mode_pulse();
    bus.btn_mode = 1'b1;
    step();
    bus.btn_mode = 1'b0;
  endtask

  logic [5:0] seq_exp [7];
  int pulses;
  logic exp_up;

  initial begin
    seq_exp = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000, 6'b000000};
    bus.t_1s = 1'b0; bus.btn_mode = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;

    // Reset state
    step(); step();
    rst = 1'b0;
    chk("rst_adj_en", bus.adj_en, 0);
    chk("rst_active", bus.adj_active, 0);
    chk("rst_up", bus.adj_up, 0);
    chk("rst_down", bus.adj_down, 0);
    chk("rst_blink", bus.blink, 0);

    // Mode walk through all fields and back to RUN
    for (int i = 0; i < 7; i++) begin
      mode_pulse();
      chk($sformatf("mode_en_%0d", i), bus.adj_en, seq_exp[i]);
      chk($sformatf("mode_act_%0d", i), bus.adj_active, (i < 6) ? 1 : 0);
    end

    // Hold-to-repeat in A_MIN
    mode_pulse(); mode_pulse();
    chk("min_en", bus.adj_en, 6'b000010);
    bus.btn_up = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step();
      exp_up = (c == 1 || c == 11 || c == 15 || c == 19 || c == 23 || c == 27);
      chk($sformatf("rpt_up_c%0d", c), bus.adj_up, exp_up);
      chk($sformatf("rpt_en_dn_c%0d", c), {bus.adj_en, bus.adj_down}, {6'b000010, 1'b0});
    end
    bus.btn_up = 1'b0;
    step();

    // Both keys held in A_HOUR
    mode_pulse();
    chk("hour_en", bus.adj_en, 6'b000100);
    bus.btn_up = 1'b1;
    step();
    chk("both_first_up", bus.adj_up, 1);
    bus.btn_down = 1'b1;
    pulses = 0;
    for (int c = 0; c < 16; c++) begin
      step();
      pulses += int'(bus.adj_up) + int'(bus.adj_down);
    end
    chk("both_no_pulses", pulses, 0);
    bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    step();
    bus.btn_down = 1'b1;
    step();
    chk("both_then_down", {bus.adj_up, bus.adj_down}, 2'b01);
    step();
    chk("down_single", bus.adj_down, 0);
    bus.btn_down = 1'b0;
    step();

    // Timeout in A_DAY with restart by key press
    mode_pulse();
    chk("day_en", bus.adj_en, 6'b001000);
    chk("day_blink0", bus.blink, 0);
    bus.t_1s = 1'b1; step(); bus.t_1s = 1'b0;
    chk("tick1_blink", bus.blink, 1);
    step();
    bus.t_1s = 1'b1; step(); bus.t_1s = 1'b0;
    chk("tick2_blink", bus.blink, 0);
    bus.btn_up = 1'b1; step(); bus.btn_up = 1'b0;
    chk("day_press_up", bus.adj_up, 1);
    step();
    bus.t_1s = 1'b1; step(); bus.t_1s = 1'b0;
    step();
    bus.t_1s = 1'b1; step(); bus.t_1s = 1'b0;
    step();
    chk("to_restarted", bus.adj_active, 1);
    bus.t_1s = 1'b1; step(); bus.t_1s = 1'b0;
    step();
    chk("to_en", bus.adj_en, 0);
    chk("to_active", bus.adj_active, 0);
    chk("to_blink", bus.blink, 0);

    // Mode and press in the same cycle in A_SEC
    mode_pulse();
    chk("sec_en", bus.adj_en, 6'b000001);
    bus.btn_mode = 1'b1; bus.btn_up = 1'b1;
    step();
    bus.btn_mode = 1'b0;
    chk("modepress_en", bus.adj_en, 6'b000010);
    chk("modepress_up", bus.adj_up, 0);
    pulses = 0;
    for (int c = 0; c < 14; c++) begin
      step();
      pulses += int'(bus.adj_up);
    end
    chk("modepress_norpt", pulses, 0);
    bus.btn_up = 1'b0;
    step();

    // Key held across reset in A_YEAR, then keys in RUN
    for (int i = 0; i < 4; i++) mode_pulse();
    chk("year_en", bus.adj_en, 6'b100000);
    bus.btn_up = 1'b1;
    step();
    chk("year_up", bus.adj_up, 1);
    rst = 1'b1;
    step();
    chk("rst_mid_en", bus.adj_en, 0);
    chk("rst_mid_up", bus.adj_up, 0);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      pulses += int'(bus.adj_up);
    end
    chk("held_thru_rst", pulses, 0);
    bus.btn_up = 1'b0; step();
    bus.btn_up = 1'b1; step();
    chk("run_press_up", bus.adj_up, 0);
    bus.btn_up = 1'b0; step();
    chk("run_active", bus.adj_active, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
